// File: rtl/trace_pkg.sv
// Shared definitions for the trace capture path (capture FSM, graph, vga timing).
package trace_pkg;

  typedef enum logic [1:0] {
    TRC_IDLE    = 2'd0,
    TRC_ARMED   = 2'd1,
    TRC_CAPTURE = 2'd2,
    TRC_DONE    = 2'd3
  } trc_state_e;

  localparam int unsigned DEFAULT_DEPTH = 640;
  localparam int unsigned SCREEN_W      = 640;

endpackage

// File: rtl/trace_capture_if.sv
// Bundle between sampling/vga front-end, trace_capture and the graph renderer.
// master = stimulus/display side, slave = trace_capture.
interface trace_capture_if #(
  parameter int unsigned STATE_W = 20
) ();

  logic               start_stop;
  logic               sample_en;
  logic [STATE_W-1:0] state_in;
  logic [STATE_W-1:0] trig_mask;
  logic [10:0]        x;
  logic [9:0]         y;
  logic [STATE_W-1:0] rd_state;
  logic               rd_valid;
  logic               armed;
  logic               busy;
  logic               done;

  modport master (
    output start_stop, sample_en, state_in, trig_mask, x, y,
    input  rd_state, rd_valid, armed, busy, done
  );

  modport slave (
    input  start_stop, sample_en, state_in, trig_mask, x, y,
    output rd_state, rd_valid, armed, busy, done
  );

endinterface

// File: rtl/trace_ram.sv
// Simple dual-port sample buffer: synchronous write, synchronous read, no array reset
// so it maps onto block RAM.
module trace_ram #(
  parameter int unsigned WIDTH  = 20,
  parameter int unsigned DEPTH  = 640,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port and registered read port share one clock.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/trace_capture.sv
// Triggered sample store: arm on start_stop rise, trigger on a masked change of the
// state word, record DEPTH samples, then freeze and serve them by pixel column.
module trace_capture
  import trace_pkg::*;
#(
  parameter int unsigned STATE_W = 20,
  parameter int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter int unsigned ADDR_W  = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  trace_capture_if.slave trc
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [10:0]       XDepth   = 11'(DEPTH);

  trc_state_e         state_q, state_d;
  logic               ss_q;
  logic [STATE_W-1:0] prev_q, prev_d;
  logic               prev_vld_q, prev_vld_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic               pend_q, pend_d;
  logic               armed_q, busy_q, done_q, rd_valid_q;

  logic               ss_rise;
  logic               trig_hit;
  logic               x_in_range;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_waddr;
  logic [ADDR_W-1:0]  ram_raddr;
  logic [STATE_W-1:0] ram_rdata;

  assign ss_rise    = trc.start_stop & ~ss_q;
  // Only a change against a sample seen since arming counts as a trigger.
  assign trig_hit   = trc.sample_en & prev_vld_q &
                      (((trc.state_in ^ prev_q) & trc.trig_mask) != '0);
  assign x_in_range = trc.x < XDepth;
  assign ram_raddr  = x_in_range ? trc.x[ADDR_W-1:0] : '0;

  // Next-state, write strobe and trigger bookkeeping.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    pend_d     = pend_q;
    ram_we     = 1'b0;
    ram_waddr  = wr_ptr_q;
    unique case (state_q)
      TRC_IDLE: begin
        // A sample coinciding with the arming edge is ignored.
        if (ss_rise) begin
          state_d    = TRC_ARMED;
          prev_vld_d = 1'b0;
        end
      end
      TRC_ARMED: begin
        if (!trc.start_stop) begin
          state_d  = TRC_IDLE;
          wr_ptr_d = '0;
        end else if (trc.sample_en) begin
          prev_d     = trc.state_in;
          prev_vld_d = 1'b1;
          if (trig_hit) begin
            ram_we    = 1'b1;
            ram_waddr = '0;
            wr_ptr_d  = ADDR_W'(1);
            state_d   = TRC_CAPTURE;
          end
        end
      end
      TRC_CAPTURE: begin
        // Abort beats the final write.
        if (!trc.start_stop) begin
          state_d  = TRC_IDLE;
          wr_ptr_d = '0;
        end else if (trc.sample_en) begin
          ram_we = 1'b1;
          if (wr_ptr_q == LastAddr) begin
            state_d  = TRC_DONE;
            wr_ptr_d = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      TRC_DONE: begin
        // Re-arm waits for row 0 so one frame never mixes old and new status.
        if (!trc.start_stop) begin
          pend_d = 1'b0;
        end else if ((ss_rise || pend_q) && (trc.y == '0)) begin
          state_d    = TRC_ARMED;
          prev_vld_d = 1'b0;
          pend_d     = 1'b0;
        end else if (ss_rise) begin
          pend_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State, registered status decodes and the read-valid pipeline stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TRC_IDLE;
      ss_q       <= 1'b0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      wr_ptr_q   <= '0;
      pend_q     <= 1'b0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ss_q       <= trc.start_stop;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      pend_q     <= pend_d;
      armed_q    <= (state_d == TRC_ARMED);
      busy_q     <= (state_d == TRC_CAPTURE);
      done_q     <= (state_d == TRC_DONE);
      rd_valid_q <= (state_q == TRC_DONE) && x_in_range;
    end
  end

  trace_ram #(
    .WIDTH  (STATE_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (trc.state_in),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Data is forced to zero whenever it is not valid (capture, out of range, reset).
  assign trc.rd_state = rd_valid_q ? ram_rdata : '0;
  assign trc.rd_valid = rd_valid_q;
  assign trc.armed    = armed_q;
  assign trc.busy     = busy_q;
  assign trc.done     = done_q;

endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture: directed sequences, a readout vector table and a random run,
// all cross-checked every cycle against a queue-based behavioural model.
module tb_trace_capture;

  localparam int unsigned SW = 20;
  localparam int unsigned DP = 640;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trace_capture_if #(.STATE_W(SW)) trc ();

  trace_capture #(
    .STATE_W (SW),
    .DEPTH   (DP),
    .ADDR_W  (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .trc   (trc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: mode flags, a queue for the capture in progress, frozen image.
  logic          m_armed, m_cap, m_done, m_pend, m_ss_prev, m_have_prev;
  logic [SW-1:0] m_prev;
  logic [SW-1:0] m_buf[$];
  logic [SW-1:0] m_mem[DP];
  logic          m_exp_valid;
  logic [SW-1:0] m_exp_data;

  typedef struct {
    logic [10:0]   x;
    logic [SW-1:0] exp_state;
    logic          exp_valid;
  } rd_vec_t;
  rd_vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_armed = 0; m_cap = 0; m_done = 0; m_pend = 0; m_ss_prev = 0; m_have_prev = 0;
    m_prev = '0; m_buf.delete(); m_exp_valid = 0; m_exp_data = '0;
  endtask

  task automatic model_step();
    logic ss, se, rise;
    logic [SW-1:0] si;
    ss = trc.start_stop; se = trc.sample_en; si = trc.state_in;
    rise = ss && !m_ss_prev;
    m_exp_valid = m_done && (int'(trc.x) < DP);
    m_exp_data  = '0;
    if (m_exp_valid) m_exp_data = m_mem[int'(trc.x)];
    if (m_armed) begin
      if (!ss) m_armed = 0;
      else if (se) begin
        if (m_have_prev && (((si ^ m_prev) & trc.trig_mask) != 0)) begin
          m_buf.delete();
          m_buf.push_back(si);
          m_armed = 0;
          m_cap = 1;
        end
        m_prev = si;
        m_have_prev = 1;
      end
    end else if (m_cap) begin
      if (!ss) begin
        m_cap = 0;
        m_buf.delete();
      end else if (se) begin
        m_buf.push_back(si);
        if (m_buf.size() == DP) begin
          for (int i = 0; i < int'(DP); i++) m_mem[i] = m_buf[i];
          m_cap = 0;
          m_done = 1;
        end
      end
    end else if (m_done) begin
      if (!ss) m_pend = 0;
      else if ((rise || m_pend) && trc.y == 0) begin
        m_done = 0; m_armed = 1; m_have_prev = 0; m_pend = 0;
      end else if (rise) m_pend = 1;
    end else if (rise) begin
      m_armed = 1;
      m_have_prev = 0;
    end
    m_ss_prev = ss;
  endtask

  // One clock: advance the model on the pre-edge inputs, then compare just after the edge.
  task automatic tick();
    if (!rst_n) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    chk("model", {8'd0, trc.armed, trc.busy, trc.done, trc.rd_valid, trc.rd_state},
        {8'd0, m_armed, m_cap, m_done, m_exp_valid, m_exp_data});
  endtask

  task automatic chk_flags(input string name, input logic a, input logic b, input logic d);
    chk(name, {29'd0, trc.armed, trc.busy, trc.done}, {29'd0, a, b, d});
  endtask

  initial begin
    vecs[0] = '{11'd0,    20'd1,   1'b1};
    vecs[1] = '{11'd1,    20'd2,   1'b1};
    vecs[2] = '{11'd320,  20'd321, 1'b1};
    vecs[3] = '{11'd639,  20'd640, 1'b1};
    vecs[4] = '{11'd640,  20'd0,   1'b0};
    vecs[5] = '{11'd700,  20'd0,   1'b0};
    vecs[6] = '{11'd2047, 20'd0,   1'b0};
    vecs[7] = '{11'd100,  20'd101, 1'b1};

    trc.start_stop = 0; trc.sample_en = 0; trc.state_in = '0; trc.trig_mask = '0;
    trc.x = '0; trc.y = '0;
    model_reset();

    // Reset state
    tick(); tick();
    chk_flags("reset_flags", 0, 0, 0);
    chk("reset_rd", {11'd0, trc.rd_valid, trc.rd_state}, 32'd0);
    #3 rst_n = 1;
    tick();

    // Basic capture, trig_mask = 1, ramp after five zeros
    trc.start_stop = 1; trc.trig_mask = 20'h00001;
    tick();
    chk_flags("arm", 1, 0, 0);
    trc.sample_en = 1;
    for (int i = 0; i < 5; i++) begin
      trc.state_in = '0;
      tick();
    end
    chk_flags("no_trig_on_zero", 1, 0, 0);
    for (int v = 1; v <= 640; v++) begin
      trc.state_in = 20'(v);
      tick();
      if (v == 1)   chk_flags("trig_first", 0, 1, 0);
      if (v == 639) chk_flags("pre_last", 0, 1, 0);
      if (v == 640) chk_flags("done_640", 0, 0, 1);
    end
    trc.sample_en = 0;
    for (int i = 0; i < 640; i++) begin
      trc.x = 11'(i);
      tick();
      chk("ramp_rd", {11'd0, trc.rd_valid, trc.rd_state}, {11'd0, 1'b1, 20'(i + 1)});
    end

    // Readout vector table
    for (int i = 0; i < 8; i++) begin
      trc.x = vecs[i].x;
      tick();
      chk("tbl_rd", {11'd0, trc.rd_valid, trc.rd_state},
          {11'd0, vecs[i].exp_valid, vecs[i].exp_state});
    end

    // Re-arm deferral while y != 0
    trc.start_stop = 0;
    tick();
    chk_flags("done_hold_low", 0, 0, 1);
    trc.y = 10'd200; trc.start_stop = 1; trc.x = 11'd10;
    for (int i = 0; i < 6; i++) tick();
    chk_flags("defer", 0, 0, 1);
    chk("defer_rd", {11'd0, trc.rd_valid, trc.rd_state}, {11'd0, 1'b1, 20'd11});
    trc.y = '0;
    tick();
    chk_flags("rearm_y0", 1, 0, 0);

    // Abort at wr_ptr = 300
    trc.sample_en = 1; trc.state_in = '0;
    tick();
    for (int v = 1; v <= 300; v++) begin
      trc.state_in = 20'(v);
      tick();
    end
    chk_flags("pre_abort", 0, 1, 0);
    trc.start_stop = 0; trc.state_in = 20'd301;
    tick();
    chk_flags("abort", 0, 0, 0);
    trc.sample_en = 0;
    for (int i = 0; i < 4; i++) begin
      trc.x = 11'(i * 213);
      tick();
      chk("abort_rd", {31'd0, trc.rd_valid}, 32'd0);
    end

    // Masked bits: only bit 0 toggles, mask on bit 19
    trc.start_stop = 1; trc.trig_mask = 20'h80000;
    tick();
    trc.sample_en = 1;
    for (int i = 0; i < 10000; i++) begin
      trc.state_in = 20'(i & 1);
      tick();
    end
    chk_flags("masked", 1, 0, 0);

    // Reset at wr_ptr = 100
    trc.trig_mask = 20'h00001; trc.state_in = '0;
    tick();
    chk_flags("trig2", 0, 1, 0);
    for (int v = 1; v < 100; v++) begin
      trc.state_in = 20'(v);
      tick();
    end
    trc.x = 11'd5;
    #2 rst_n = 0;
    #1;
    chk_flags("async_rst", 0, 0, 0);
    chk("async_rst_rd", {11'd0, trc.rd_valid, trc.rd_state}, 32'd0);
    trc.start_stop = 0; trc.sample_en = 0;
    tick();
    #3 rst_n = 1;
    tick();
    chk_flags("post_rst", 0, 0, 0);

    // Random run against the model
    trc.start_stop = 1;
    for (int c = 0; c < 8000; c++) begin
      if ($urandom_range(0, 1499) == 0) trc.start_stop = ~trc.start_stop;
      if (!trc.start_stop && $urandom_range(0, 19) == 0) trc.start_stop = 1;
      if (c % 500 == 0) begin
        case ($urandom_range(0, 4))
          0: trc.trig_mask = 20'h00000;
          1: trc.trig_mask = 20'h80000;
          2: trc.trig_mask = 20'h00003;
          default: trc.trig_mask = 20'($urandom);
        endcase
      end
      trc.sample_en = ($urandom_range(0, 3) != 0);
      trc.state_in  = ($urandom_range(0, 2) == 0) ? 20'($urandom) : trc.state_in;
      trc.x         = 11'($urandom_range(0, 799));
      trc.y         = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 524));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
